force_release_bank: RTL
=======================

// Module: force_release_bank
// PURPOSE
//  Synthesisable, parametrised bank of CHANNELS override registers for debug/bring-up.
//  Each channel normally tracks a driven source value. A debug controller can force it to a value.
//  On release, the channel either returns to the source at once (net-style) or keeps the
//  forced value until the source next updates (register-style).
//  Sits between functional logic and its consumers, on debug-controlled signals.
// PARAMETERS
//  CHANNELS     4   number of independent override channels (>=1)
//  WIDTH        8   data width per channel (>=1)
//  RESET_VALUE  0   WIDTH-bit value loaded into out and the source shadow on reset
//  CNT_W        8   width of the saturating force-event counter
// PORTS
//  clk            in   1               single clock; all logic is rising-edge
//  reset          in   1               synchronous, active-high reset
//  drv_data       in   CHANNELS*WIDTH  source value; channel i occupies [i*WIDTH +: WIDTH]
//  drv_valid      in   CHANNELS        per-channel source update strobe
//  force_en       in   CHANNELS        level: channel is forced while high
//  force_data     in   CHANNELS*WIDTH  forced value, same packing as drv_data
//  release_req    in   CHANNELS        per-channel release pulse
//  release_mode   in   CHANNELS        0 = net-style release, 1 = register-style (hold)
//  cnt_clr        in   1               clears the event counter
//  out_data       out  CHANNELS*WIDTH  registered channel outputs
//  forced_status  out  CHANNELS        1 while channel state is FORCED
//  held_status    out  CHANNELS        1 while channel state is HELD
//  force_events   out  CNT_W           saturating count of entries into FORCED
// BEHAVIOUR
//  Reset (sync, highest priority):
//   - every channel: state = NORMAL, out = src_q = RESET_VALUE
//   - status outputs = 0, force_events = 0
//  Source shadow src_q: loads drv_data on drv_valid in every state, including while forced.
//  All outputs are registered; an input in cycle n appears on out_data in cycle n+1.
//  Per-channel FSM, one step per cycle:
//   NORMAL
//    - force_en=1 -> FORCED, out <= force_data
//    - else if drv_valid -> out <= drv_data
//    - else out holds
//    - release_req is ignored
//   FORCED
//    - force_en=1 -> stay FORCED; out <= force_data, re-sampled every cycle
//    - release_req=1 and force_en=0:
//        release_mode=0 -> NORMAL; out <= drv_valid ? drv_data : src_q
//        release_mode=1 -> HELD; out keeps its last forced value
//    - force_en=0 and no release_req -> stay FORCED, out holds its last forced value
//      (deassertion alone is not a release)
//   HELD
//    - force_en=1 -> FORCED, out <= force_data
//    - else if drv_valid -> NORMAL, out <= drv_data
//      (the source must re-apply a value to displace the held value)
//    - else hold; release_req is ignored
//  Simultaneous events:
//   - force_en beats release_req and drv_valid
//   - release_mode is sampled only in the cycle release_req is accepted
//  Event counter:
//   - force_events += number of channels entering FORCED from NORMAL or HELD this cycle
//     (popcount, so several channels in one cycle add several)
//   - saturates at 2^CNT_W-1
//   - cnt_clr has priority over increments in the same cycle; reset also clears it
//  Reset mid-force: channel returns to NORMAL/RESET_VALUE next cycle; no forced value survives.
// STRUCTURE
//  force_release_pkg: typedef enum logic[1:0] {ST_NORMAL, ST_FORCED, ST_HELD} fr_state_t;
//   REL_NET=1'b0, REL_REG=1'b1 constants.
//  Sub-module force_release_channel: one channel's FSM, src_q and out register, plus an
//   enter_forced pulse. Instanced CHANNELS times in a generate loop.
//  Top level: counter, popcount and port packing.
// TESTING
//  1 W=8, C=4. Reset, then ch0 drv 0x5A -> out0=0x5A one cycle later; ch1-3 stay 0x00.
//  2 Force ch1 with 0x33. Drive 0x77 during the force, then release with mode=0
//    -> out1=0x33 while forced, 0x77 the cycle after release.
//  3 Force ch2 with 0xF0, release with mode=1 -> out2 stays 0xF0 and held_status[2]=1.
//    Drive 0x11 -> out2=0x11 and held clears.
//  4 force_en and release_req on ch3 in the same cycle -> stays FORCED, no state change.
//    drv_valid together with a net release -> out=drv_data.
//  5 CNT_W=2; force four channels at once -> force_events=3 (saturated).
//    cnt_clr together with a new force -> 0.
//  6 Assert reset while ch0 is FORCED at 0xAA -> next cycle out0=RESET_VALUE,
//    forced_status=0, counter=0.

Source files
------------

// File: rtl/force_release_pkg.sv
// Shared types and constants for the force/release override bank.
package force_release_pkg;

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_FORCED = 2'd1,
    ST_HELD   = 2'd2
  } fr_state_t;

  localparam logic REL_NET = 1'b0;
  localparam logic REL_REG = 1'b1;

endpackage

// File: rtl/force_release_channel.sv
// One override channel: source shadow, registered output and NORMAL/FORCED/HELD state.
module force_release_channel
  import force_release_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] drv_data,
  input  logic             drv_valid,
  input  logic             force_en,
  input  logic [WIDTH-1:0] force_data,
  input  logic             release_req,
  input  logic             release_mode,
  output logic [WIDTH-1:0] out_data,
  output logic             forced,
  output logic             held,
  output logic             enter_forced
);

  fr_state_t        state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] src_q, src_d;

  always_comb begin
    state_d      = state_q;
    out_d        = out_q;
    src_d        = drv_valid ? drv_data : src_q;
    enter_forced = 1'b0;
    unique case (state_q)
      ST_NORMAL: begin
        if (force_en) begin
          state_d      = ST_FORCED;
          out_d        = force_data;
          enter_forced = 1'b1;
        end else if (drv_valid) begin
          out_d = drv_data;
        end
      end
      ST_FORCED: begin
        // Dropping force_en alone keeps the channel forced; only release_req leaves.
        if (force_en) begin
          out_d = force_data;
        end else if (release_req) begin
          if (release_mode == REL_REG) begin
            state_d = ST_HELD;
          end else begin
            state_d = ST_NORMAL;
            out_d   = drv_valid ? drv_data : src_q;
          end
        end
      end
      ST_HELD: begin
        if (force_en) begin
          state_d      = ST_FORCED;
          out_d        = force_data;
          enter_forced = 1'b1;
        end else if (drv_valid) begin
          state_d = ST_NORMAL;
          out_d   = drv_data;
        end
      end
      default: begin
        state_d = ST_NORMAL;
        out_d   = src_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_NORMAL;
      out_q   <= RESET_VALUE;
      src_q   <= RESET_VALUE;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      src_q   <= src_d;
    end
  end

  assign out_data = out_q;
  assign forced   = (state_q == ST_FORCED);
  assign held     = (state_q == ST_HELD);

endmodule

// File: rtl/force_release_bank.sv
// Bank of debug override channels with a saturating count of force entries.
module force_release_bank
  import force_release_pkg::*;
#(
  parameter int               CHANNELS    = 4,
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               CNT_W       = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] drv_data,
  input  logic [CHANNELS-1:0]       drv_valid,
  input  logic [CHANNELS-1:0]       force_en,
  input  logic [CHANNELS*WIDTH-1:0] force_data,
  input  logic [CHANNELS-1:0]       release_req,
  input  logic [CHANNELS-1:0]       release_mode,
  input  logic                      cnt_clr,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]       forced_status,
  output logic [CHANNELS-1:0]       held_status,
  output logic [CNT_W-1:0]          force_events
);

  localparam int PC_W  = $clog2(CHANNELS + 1);
  localparam int SUM_W = CNT_W + PC_W;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

  logic [CHANNELS-1:0] enter_forced;
  logic [PC_W-1:0]     enter_cnt;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [PC_W-1:0]  b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    if (s > CNT_MAX) return CNT_MAX[CNT_W-1:0];
    return s[CNT_W-1:0];
  endfunction

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    force_release_channel #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .drv_data     (drv_data[g*WIDTH +: WIDTH]),
      .drv_valid    (drv_valid[g]),
      .force_en     (force_en[g]),
      .force_data   (force_data[g*WIDTH +: WIDTH]),
      .release_req  (release_req[g]),
      .release_mode (release_mode[g]),
      .out_data     (out_data[g*WIDTH +: WIDTH]),
      .forced       (forced_status[g]),
      .held         (held_status[g]),
      .enter_forced (enter_forced[g])
    );
  end

  always_comb begin
    enter_cnt = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      enter_cnt = enter_cnt + PC_W'(enter_forced[i]);
    end
    cnt_d = cnt_clr ? '0 : sat_add(cnt_q, enter_cnt);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign force_events = cnt_q;

endmodule
